// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 round-robin stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Elaboration-time ceil(log2(n)); used to validate the select width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer and an optional
// packet lock that pins the grant to one channel until its last word.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  request,
  input  logic                 advance,
  input  logic                 lock_hold,
  output logic [CHANNELS-1:0]  grant,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  logic [SEL_WIDTH-1:0] ptr_reg;
  logic [SEL_WIDTH-1:0] ptr_next;
  logic                 lock_reg;
  logic                 lock_next;
  logic [SEL_WIDTH-1:0] lock_idx_reg;
  logic [SEL_WIDTH-1:0] lock_idx_next;

  logic [CHANNELS-1:0]  hi_mask;
  logic [CHANNELS-1:0]  hi_req;
  logic [CHANNELS-1:0]  pick;
  logic [CHANNELS-1:0]  rr_grant;
  logic [CHANNELS-1:0]  lock_grant;

  generate
    if (SEL_WIDTH != clog2(CHANNELS)) begin : g_bad_width
      $error("rr_arbiter: SEL_WIDTH must equal ceil(log2(CHANNELS))");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign hi_mask[gi]    = (SEL_WIDTH'(gi) >= ptr_reg);
      assign lock_grant[gi] = (SEL_WIDTH'(gi) == lock_idx_reg) && request[gi];
    end
  endgenerate

  // Requests at or above the pointer win; otherwise wrap to the lowest one.
  assign hi_req   = request & hi_mask;
  assign pick     = (|hi_req) ? hi_req : request;
  assign rr_grant = pick & (~pick + CHANNELS'(1));
  assign grant    = lock_reg ? lock_grant : rr_grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_idx = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    ptr_next      = ptr_reg;
    lock_next     = lock_reg;
    lock_idx_next = lock_idx_reg;
    if (advance) begin
      if (lock_hold) begin
        lock_next     = 1'b1;
        lock_idx_next = grant_idx;
      end else begin
        lock_next = 1'b0;
        ptr_next  = (grant_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0
                                                           : grant_idx + SEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 valid/ready stream multiplexer, fixed or round-robin select.
// Define MUX_NTO1_RR_PKT_LOCK_EN to add In_Last and packet-locked arbitration.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int CHANNELS    = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Mode,
  input  logic [SEL_WIDTH-1:0]            Selector,
  input  logic [CHANNELS*WORD_LENGTH-1:0] In_Data,
  input  logic [CHANNELS-1:0]             In_Valid,
`ifdef MUX_NTO1_RR_PKT_LOCK_EN
  input  logic [CHANNELS-1:0]             In_Last,
`endif
  output logic [CHANNELS-1:0]             In_Ready,
  output logic [WORD_LENGTH-1:0]          Out_Data,
  output logic                            Out_Valid,
  input  logic                            Out_Ready,
  output logic [SEL_WIDTH-1:0]            Out_Channel
);

  logic [WORD_LENGTH-1:0] ch_data [CHANNELS];
  logic [CHANNELS-1:0]    fixed_grant;
  logic [CHANNELS-1:0]    rr_grant;
  logic [CHANNELS-1:0]    grant;
  logic [SEL_WIDTH-1:0]   rr_idx;
  logic [SEL_WIDTH-1:0]   sel_idx;
  logic [WORD_LENGTH-1:0] sel_data;
  logic                   load_en;
  logic                   transfer;
  logic                   rr_advance;
  logic                   lock_hold;

  logic                   out_valid_reg;
  logic                   out_valid_next;
  logic [WORD_LENGTH-1:0] out_data_reg;
  logic [WORD_LENGTH-1:0] out_data_next;
  logic [SEL_WIDTH-1:0]   out_channel_reg;
  logic [SEL_WIDTH-1:0]   out_channel_next;

  // An out-of-range Selector matches no channel, so it yields no grant.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign ch_data[gi]     = In_Data[gi*WORD_LENGTH +: WORD_LENGTH];
      assign fixed_grant[gi] = (Selector == SEL_WIDTH'(gi)) && In_Valid[gi];
      assign In_Ready[gi]    = load_en && grant[gi] && !reset;
    end
  endgenerate

  assign load_en    = !out_valid_reg || Out_Ready;
  assign grant      = (Mode == MODE_RR) ? rr_grant : fixed_grant;
  assign sel_idx    = (Mode == MODE_RR) ? rr_idx : Selector;
  assign transfer   = |In_Ready;
  assign rr_advance = transfer && (Mode == MODE_RR);

`ifdef MUX_NTO1_RR_PKT_LOCK_EN
  assign lock_hold = ~|(In_Last & rr_grant);
`else
  assign lock_hold = 1'b0;
`endif

  rr_arbiter #(
    .CHANNELS  (CHANNELS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (In_Valid),
    .advance   (rr_advance),
    .lock_hold (lock_hold),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Grant is one-hot, so an AND-OR mux avoids any out-of-range indexing.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | ch_data[i];
      end
    end
  end

  always_comb begin
    out_valid_next   = out_valid_reg;
    out_data_next    = out_data_reg;
    out_channel_next = out_channel_reg;
    if (load_en) begin
      out_valid_next = transfer;
      if (transfer) begin
        out_data_next    = sel_data;
        out_channel_next = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_channel_reg <= '0;
    end else begin
      out_valid_reg   <= out_valid_next;
      out_data_reg    <= out_data_next;
      out_channel_reg <= out_channel_next;
    end
  end

  assign Out_Valid   = out_valid_reg;
  assign Out_Data    = out_data_reg;
  assign Out_Channel = out_channel_reg;

endmodule
